qam4_mixer: RTL and testbench
=============================

# qam4_mixer

4-QAM baseband-to-carrier mixer with an integrated quadrature carrier generator. A free-running phase counter drives a sine/cosine lookup table. Each mixer strobe multiplies the current 2-bit symbol's I/Q signs onto cos/sin and emits one 8-bit signed carrier sample. It sits between the symbol sampler and the serializer in the QAM transmit path.

## Interface
- `LUT_DEPTH`, default 32: carrier samples per period. Power of two, at least 8.
- `AMP`, default 127: LUT peak amplitude. Must be at most 127.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sym_valid` in 1: loads `sym_in` into the symbol register.
- `sym_in` in 2: 4-QAM symbol. Bit 1 is the I sign, bit 0 is the Q sign.
- `mix_en` in 1: mixer strobe. Produces one output sample.
- `sin_out` out 8: signed carrier sine sample.
- `cos_out` out 8: signed carrier cosine sample.
- `signal_out` out 8: signed mixed sample.

## Operation
- Phase register `ph`:
  - width log2(`LUT_DEPTH`);
  - increments by 1 every clock, unconditionally;
  - wraps from `LUT_DEPTH`-1 to 0.
- LUT contents:
  - sin[k] = round(`AMP`·sin(2πk/`LUT_DEPTH`));
  - cos[k] = round(`AMP`·cos(2πk/`LUT_DEPTH`));
  - round half away from zero;
  - table computed at elaboration.
- `sin_out`/`cos_out` are registered and always equal the LUT entries for the current `ph`.
- Symbol register `sym_q`: on `sym_valid`=1, `sym_q` <= `sym_in`. Otherwise it holds.
- Symbol mapping (sign, Gray):
  - I = +1 if `sym_q[1]`=0, else −1;
  - Q = +1 if `sym_q[0]`=0, else −1.
- Mixing on `mix_en`=1:
  - sum = I·`cos_out` + Q·`sin_out`, computed as 9-bit signed, range ±254;
  - `signal_out` <= sum >>> 1 (arithmetic shift; truncation toward −∞);
  - the result always fits in 8 bits.
- `mix_en`=0: `signal_out` holds.
- The mixer uses pre-edge values of `sym_q`, `sin_out` and `cos_out`.

## Timing
- Reset values: `ph`=0, `sin_out`=0, `cos_out`=`AMP`, `sym_q`=2'b00, `signal_out`=0.
- Reset asserted mid-operation clears all state immediately. The first `ph` increment happens on the first rising edge after deassertion.
- Carrier outputs change on every edge and have one-period `LUT_DEPTH`·clk periodicity.
- Latency:
  - `sym_valid` edge to a sample using the new symbol: the next `mix_en` edge strictly after the load;
  - `mix_en` edge to `signal_out` valid: registered, visible after that edge.
- `sym_valid` and `mix_en` in the same cycle: the mixer uses the old `sym_q`, and the new symbol is loaded.
- `mix_en` may be held high continuously. The block then produces one sample per clock.
- There is no handshake or backpressure.

## Configuration
- `QAM_MIXER_ROUND_EN`:
  - When defined, the output is rounded: `signal_out` <= (sum + 1) >>> 1 (round half up). A sum of +254 would give 127.5, which is clamped to 127 and cannot overflow.
  - When undefined, plain truncation: sum >>> 1.

## Structure
- Shared package `qam_pkg` holds:
  - the 2-bit symbol typedef;
  - the 8-bit signed sample typedef;
  - `AMP`/`LUT_DEPTH` defaults;
  - the LUT-generation function.
- One sub-module, `qam_carrier_lut`, contains:
  - the phase counter;
  - the registered sin/cos lookup;
  - ports `clk`, `rst`, `sin_out`, `cos_out`.
- The top level holds the symbol register, sign mapping, adder and output register.

## Test plan
- Reset, then release:
  - `sin_out`=0, `cos_out`=127, `signal_out`=0;
  - after 8 edges (`LUT_DEPTH`=32), `sin_out`=127 and `cos_out`=0.
- Load `sym_in`=00, pulse `mix_en` at ph=0 (sin 0, cos 127) -> `signal_out`=63. With `QAM_MIXER_ROUND_EN`: 64.
- `sym_in`=11 at ph=0 -> `signal_out`=−64. With `QAM_MIXER_ROUND_EN`: −63.
- At ph=4 (sin=cos=90):
  - `sym_in`=00 -> 90;
  - `sym_in`=01 -> 0;
  - `sym_in`=11 -> −90.
- `sym_valid` and `mix_en` coincident, old sym 00 and new 11, at ph=0 -> output 63. The next `mix_en` at ph=0 -> −64.
- Run 32 clocks -> `ph` wraps and `sin_out`/`cos_out` return to 0/127. Assert `rst` mid-period -> all outputs return to their reset values without a clock edge.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared types, defaults and LUT-generation helper for the 4-QAM transmit path.
// The rounding option of qam4_mixer is selected with the QAM_MIXER_ROUND_EN macro.
package qam_pkg;

  // 2-bit 4-QAM symbol: bit 1 is the I sign, bit 0 is the Q sign
  typedef logic [1:0] symbol_t;

  // 8-bit signed carrier / mixed sample
  typedef logic signed [7:0] sample_t;

  localparam int AMP_DEFAULT       = 127;
  localparam int LUT_DEPTH_DEFAULT = 32;

  // One carrier table entry, round(amp * sin|cos(2*pi*k/depth)), half away from zero.
  // Only ever called with constant arguments, so it folds away at elaboration.
  function automatic sample_t lutValue(input int k, input int depth, input int amp,
                                       input bit cosine);
    real angle;
    real v;
    int  r;
    angle = 2.0 * 3.14159265358979323846 * real'(k) / real'(depth);
    v = real'(amp) * (cosine ? $cos(angle) : $sin(angle));
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(-v + 0.5);
    return sample_t'(r);
  endfunction

endpackage

// File: rtl/qam_carrier_lut.sv
// Quadrature carrier generator: free-running phase counter feeding a
// registered sine/cosine lookup. Outputs always match the table entry of the
// current phase, so reset lands on phase 0 (sin 0, cos AMP).
module qam_carrier_lut
  import qam_pkg::*;
#(
  parameter int LUT_DEPTH = LUT_DEPTH_DEFAULT,
  parameter int AMP       = AMP_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  output sample_t sin_out,
  output sample_t cos_out
);

  localparam int PH_W = $clog2(LUT_DEPTH);

  sample_t          sinTab [LUT_DEPTH];
  sample_t          cosTab [LUT_DEPTH];
  logic [PH_W-1:0]  ph_q;
  logic [PH_W-1:0]  ph_d;

  // Elaboration-time tables, one constant entry per phase
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : gTable
    assign sinTab[k] = lutValue(k, LUT_DEPTH, AMP, 1'b0);
    assign cosTab[k] = lutValue(k, LUT_DEPTH, AMP, 1'b1);
  end

  // Power-of-two depth lets the counter wrap naturally
  assign ph_d = ph_q + 1'b1;

  // Advance phase every clock and register the table entries of the new phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q    <= '0;
      sin_out <= sinTab[0];
      cos_out <= cosTab[0];
    end else begin
      ph_q    <= ph_d;
      sin_out <= sinTab[ph_d];
      cos_out <= cosTab[ph_d];
    end
  end

endmodule

// File: rtl/qam4_mixer.sv
// 4-QAM baseband-to-carrier mixer. Holds the symbol register, maps symbol bits
// to I/Q signs, sums I*cos + Q*sin and registers half of it on each mix strobe.
// Define QAM_MIXER_ROUND_EN to round the halving (half up) instead of truncating.
module qam4_mixer
  import qam_pkg::*;
#(
  parameter int LUT_DEPTH = LUT_DEPTH_DEFAULT,
  parameter int AMP       = AMP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym_in,
  input  logic       mix_en,
  output sample_t    sin_out,
  output sample_t    cos_out,
  output sample_t    signal_out
);

  symbol_t           sym_q;
  symbol_t           sym_d;
  sample_t           signal_q;
  sample_t           signal_d;
  logic signed [8:0] iTerm;
  logic signed [8:0] qTerm;
  logic signed [8:0] sum;
  logic signed [9:0] biased;
  logic signed [9:0] halved;

  qam_carrier_lut #(
    .LUT_DEPTH (LUT_DEPTH),
    .AMP       (AMP)
  ) uCarrier (
    .clk     (clk),
    .rst     (rst),
    .sin_out (sin_out),
    .cos_out (cos_out)
  );

  // Sign-map the held symbol onto the carrier and form the 9-bit sum; the
  // table never reaches -128, so negation cannot overflow
  always_comb begin
    iTerm  = sym_q[1] ? -9'(cos_out) : 9'(cos_out);
    qTerm  = sym_q[0] ? -9'(sin_out) : 9'(sin_out);
    sum    = iTerm + qTerm;
`ifdef QAM_MIXER_ROUND_EN
    biased = 10'(sum) + 10'sd1;
`else
    biased = 10'(sum);
`endif
    halved = biased >>> 1;
    // |halved| <= 127 in both modes (254+1 halves down to 127), so the cast is lossless
    signal_d = mix_en ? sample_t'(halved) : signal_q;
    sym_d    = sym_valid ? sym_in : sym_q;
  end

  // Symbol and output registers; the mixer above sees the pre-edge symbol
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_q    <= 2'b00;
      signal_q <= '0;
    end else begin
      sym_q    <= sym_d;
      signal_q <= signal_d;
    end
  end

  assign signal_out = signal_q;

endmodule

// File: tb/tb_qam4_mixer.sv
// Self-checking bench for qam4_mixer: directed test-plan steps followed by
// random symbol/strobe traffic, compared against a trigonometric reference.
module tb_qam4_mixer;

  localparam int DEPTH = 32;
  localparam int AMPL  = 127;

`ifdef QAM_MIXER_ROUND_EN
  localparam int EXP_PH0_SYM00 = 64;
  localparam int EXP_PH0_SYM11 = -63;
`else
  localparam int EXP_PH0_SYM00 = 63;
  localparam int EXP_PH0_SYM11 = -64;
`endif

  logic              clk;
  logic              rst;
  logic              symValid;
  logic [1:0]        symIn;
  logic              mixEn;
  logic signed [7:0] sinOut;
  logic signed [7:0] cosOut;
  logic signed [7:0] signalOut;

  int checks = 0;
  int errors = 0;

  // Reference state
  int modelPh;
  int expSym;
  int expSignal;

  qam4_mixer #(
    .LUT_DEPTH (DEPTH),
    .AMP       (AMPL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_valid  (symValid),
    .sym_in     (symIn),
    .mix_en     (mixEn),
    .sin_out    (sinOut),
    .cos_out    (cosOut),
    .signal_out (signalOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int roundAway(input real v);
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(-v + 0.5));
  endfunction

  function automatic int refSin(input int k);
    return roundAway(real'(AMPL) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH)));
  endfunction

  function automatic int refCos(input int k);
    return roundAway(real'(AMPL) * $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH)));
  endfunction

  function automatic int floorHalf(input int x);
    return int'($floor(real'(x) / 2.0));
  endfunction

  // Mixed sample for a symbol at a given phase, straight from the sign rules
  function automatic int refMix(input int sym, input int ph);
    int iSign;
    int qSign;
    int s;
    iSign = ((sym / 2) % 2 == 1) ? -1 : 1;
    qSign = (sym % 2 == 1) ? -1 : 1;
    s = iSign * refCos(ph) + qSign * refSin(ph);
`ifdef QAM_MIXER_ROUND_EN
    return floorHalf(s + 1);
`else
    return floorHalf(s);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_sin"}, 32'(sinOut), refSin(modelPh));
    checkOutput({tag, "_cos"}, 32'(cosOut), refCos(modelPh));
    checkOutput({tag, "_sig"}, 32'(signalOut), expSignal);
  endtask

  // One clock with the given inputs; reference updated from pre-edge state
  task automatic applyStimulus(input bit valid, input logic [1:0] sym, input bit mix);
    symValid = valid;
    symIn    = sym;
    mixEn    = mix;
    @(posedge clk);
    if (mix)   expSignal = refMix(expSym, modelPh);
    if (valid) expSym = int'(sym);
    modelPh = (modelPh + 1) % DEPTH;
    #1;
    checkAll("step");
    symValid = 1'b0;
    mixEn    = 1'b0;
  endtask

  // Idle clocks until the pre-edge phase equals target (at most DEPTH steps)
  task automatic advanceTo(input int target);
    for (int i = 0; i < DEPTH && modelPh != target; i++) applyStimulus(1'b0, 2'b00, 1'b0);
  endtask

  task automatic resetModel();
    modelPh   = 0;
    expSym    = 0;
    expSignal = 0;
  endtask

  initial begin
    rst      = 1'b1;
    symValid = 1'b0;
    symIn    = 2'b00;
    mixEn    = 1'b0;
    resetModel();

    #12;
    checkOutput("rst_sin", 32'(sinOut), 0);
    checkOutput("rst_cos", 32'(cosOut), 127);
    checkOutput("rst_sig", 32'(signalOut), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("quarter_sin", 32'(sinOut), 127);
    checkOutput("quarter_cos", 32'(cosOut), 0);

    applyStimulus(1'b1, 2'b00, 1'b0);
    advanceTo(0);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("ph0_sym00", 32'(signalOut), EXP_PH0_SYM00);

    applyStimulus(1'b1, 2'b11, 1'b0);
    advanceTo(0);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("ph0_sym11", 32'(signalOut), EXP_PH0_SYM11);

    applyStimulus(1'b1, 2'b00, 1'b0);
    advanceTo(4);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("ph4_sym00", 32'(signalOut), 90);

    applyStimulus(1'b1, 2'b01, 1'b0);
    advanceTo(4);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("ph4_sym01", 32'(signalOut), 0);

    applyStimulus(1'b1, 2'b11, 1'b0);
    advanceTo(4);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("ph4_sym11", 32'(signalOut), -90);

    applyStimulus(1'b1, 2'b00, 1'b0);
    advanceTo(0);
    applyStimulus(1'b1, 2'b11, 1'b1);
    checkOutput("coincident_old", 32'(signalOut), EXP_PH0_SYM00);
    advanceTo(0);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("coincident_new", 32'(signalOut), EXP_PH0_SYM11);

    advanceTo(0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("wrap_sin", 32'(sinOut), 0);
    checkOutput("wrap_cos", 32'(cosOut), 127);

    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 2) != 0));

    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 2'b00, 1'b1);

    advanceTo(11);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_sin", 32'(sinOut), 0);
    checkOutput("midrst_cos", 32'(cosOut), 127);
    checkOutput("midrst_sig", 32'(signalOut), 0);
    #1 rst = 1'b0;
    resetModel();
    for (int i = 0; i < 10; i++) applyStimulus(1'($urandom_range(0, 1)),
                                               2'($urandom_range(0, 3)), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
